// File: rtl/seq_bin2seg_pkg.sv
// seq_bin2seg_pkg: shared FSM states, segment patterns and BCD sizing for seq_bin2seg
package seq_bin2seg_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };
  function automatic int bcd_nibbles(input int in_w);
    int v;
    int n;
    v = (1 << in_w) - 1;
    n = 0;
    while (v > 0) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction
endpackage

// File: rtl/seg7_enc.sv
// seg7_enc: one BCD digit to {a,b,c,d,e,f,g}, dash overrides blank
module seg7_enc
  import seq_bin2seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);
  assign seg = dash ? SEG_DASH : (blank || digit > 4'd9) ? SEG_BLANK : SEG_DIGIT[digit];
endmodule

// File: rtl/seq_bin2seg.sv
// seq_bin2seg: double-dabble binary to DIGITS 7-segment digits, one bit per clock
// Define SEQ_BIN2SEG_LZB_EN to blank leading zero digits.
module seq_bin2seg
  import seq_bin2seg_pkg::*;
#(
  parameter int IN_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       binIn,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [DIGITS*7-1:0]   segOut
);
  localparam int NEED = bcd_nibbles(IN_W);
  // one spare always-zero nibble keeps the overflow slice non-empty
  localparam int NB = (NEED > DIGITS ? NEED : DIGITS) + 1;
  localparam int CW = $clog2(IN_W + 1);
  if (IN_W < 1 || IN_W > 16) begin : g_bad_in_w
    $error("seq_bin2seg: IN_W must be 1..16");
  end
  if (DIGITS < 1 || DIGITS > 5) begin : g_bad_digits
    $error("seq_bin2seg: DIGITS must be 1..5");
  end
  state_t state, state_nx;
  logic [IN_W-1:0] sh;
  logic [4*NB-1:0] bcd, adj;
  logic [CW-1:0] cnt;
  logic [DIGITS*7-1:0] seg_nx;
  logic ovf_nx;
  always_comb begin
    state_nx = state == IDLE ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == CW'(1) ? LOAD : SHIFT) : IDLE;
  end
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NB; i++)
      adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end
  assign ovf_nx = |bcd[4*NB-1:4*DIGITS];
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    logic blk;
`ifdef SEQ_BIN2SEG_LZB_EN
    assign blk = (k != 0) && (bcd[4*DIGITS-1:4*k] == '0);
`else
    assign blk = 1'b0;
`endif
    seg7_enc u_enc (
      .digit(bcd[4*k+:4]),
      .blank(blk),
      .dash (ovf_nx),
      .seg  (seg_nx[7*k+:7])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      ovf <= 1'b0;
      segOut <= '0;
      sh <= '0;
      bcd <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      done <= state == LOAD;
      if (state == IDLE && start) begin
        sh <= binIn;
        bcd <= '0;
        cnt <= CW'(IN_W);
        busy <= 1'b1;
      end
      if (state == SHIFT) begin
        {bcd, sh} <= {adj, sh} << 1;
        cnt <= cnt - 1'b1;
      end
      if (state == LOAD) begin
        segOut <= seg_nx;
        ovf <= ovf_nx;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_bin2seg.sv
// tb_seq_bin2seg: scoreboard bench for seq_bin2seg (8-bit and 10-bit builds)
module tb_seq_bin2seg;
  logic clk = 0, rst_n = 0, start = 0, start2 = 0;
  logic [7:0] binIn = 0;
  logic [9:0] bin2 = 0;
  logic busy, done, ovf, busy2, done2, ovf2;
  logic [20:0] segOut, seg2;
  logic [21:0] e, e2;
  logic [21:0] sb[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  seq_bin2seg #(.IN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .binIn(binIn),
    .busy(busy), .done(done), .ovf(ovf), .segOut(segOut)
  );
  seq_bin2seg #(.IN_W(10), .DIGITS(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .binIn(bin2),
    .busy(busy2), .done(done2), .ovf(ovf2), .segOut(seg2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      default: return 7'b1111011;
    endcase
  endfunction
  function automatic logic [21:0] model(input int v);
    logic [21:0] r;
    int p;
    p = 1;
    r[21] = v > 999;
    for (int k = 0; k < 3; k++) begin
      r[7*k+:7] = r[21] ? 7'b0000001 : seg7((v / p) % 10);
`ifdef SEQ_BIN2SEG_LZB_EN
      if (!r[21] && k > 0 && v < p) r[7*k+:7] = 7'b0000000;
`endif
      p = p * 10;
    end
    return r;
  endfunction
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) check("spurious_done", done, 0);
      else begin
        e = sb.pop_front();
        check("seg", segOut, e[20:0]);
        check("ovf", ovf, e[21]);
      end
    end
  end
  task automatic conv(input logic [7:0] v, input int pulse_at = 0, input logic [7:0] pv = 0);
    binIn = v;
    start = 1;
    sb.push_back(model(v));
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      if (c == pulse_at) binIn = pv;
      check($sformatf("busy_c%0d", c), busy, c <= 9);
      check($sformatf("done_c%0d", c), done, c == 10);
    end
  endtask
  task automatic conv2(input logic [9:0] v);
    int t;
    @(negedge clk);
    bin2 = v;
    start2 = 1;
    @(negedge clk);
    start2 = 0;
    t = 0;
    while (!done2 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("done2_seen", done2, 1);
    if (done2) begin
      e2 = model(v);
      check("seg2", seg2, e2[20:0]);
      check("ovf2", ovf2, e2[21]);
    end
  endtask
  initial begin
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_seg", segOut, 0);
    rst_n = 1;
    @(negedge clk);
    conv(0);
    @(negedge clk);
    conv(255);
    @(negedge clk);
    conv(139);
    @(negedge clk);
    conv(200, 4, 55);
    conv(7);
    @(negedge clk);
    binIn = 77;
    start = 1;
    sb.push_back(model(77));
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ovf", ovf, 0);
    check("abort_seg", segOut, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    repeat (15) @(negedge clk);
    conv(42);
    @(negedge clk);
    conv2(999);
    conv2(1023);
    conv2(5);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
